// File: rtl/uart_tx_req.sv
// uart_tx_req: requesting UART transmitter.
// Accepts a byte, raises a request to the flow controller, waits for the grant
// (bounded by CTS_TIMEOUT), then sends one 8N1/8E1/8O1 frame. All outputs are
// registered. Each one is computed from the next state so that it changes on
// the same edge as the state.
module uart_tx_req #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int CTS_TIMEOUT  = 1024
) (
    input  logic       tck,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       parity_en_i,
    input  logic       parity_odd_i,
    output logic       tx_rts_n_o,
    input  logic       tx_cts_n_i,
    input  logic       tx_enable_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       timeout_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int WW = $clog2(CTS_TIMEOUT + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(CTS_TIMEOUT - 1);
    localparam logic [WW-1:0] WAIT_MAX  = '1;
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_en_q, par_en_d;
    // The parity bit is folded at accept time, so only one bit has to be held
    // while the shift register empties.
    logic            par_bit_q, par_bit_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic            stop_idx_q, stop_idx_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            tx_q, tx_d;
    logic            rts_n_q, rts_n_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;
    logic            bit_end;

    assign bit_end = (bit_cnt_q == '0);

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = 1'b0;

        // The bit timer runs in every frame state and reloads at each bit boundary.
        if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP})
            bit_cnt_d = bit_end ? BIT_LAST : bit_cnt_q - 1'b1;

        case (state_q)
            S_IDLE: begin
                if (valid_i && ready_q) begin
                    shift_d    = data_i;
                    par_en_d   = parity_en_i;
                    par_bit_d  = (^data_i) ^ parity_odd_i;
                    wait_cnt_d = '0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                // A grant wins over a timeout that falls in the same cycle.
                if (!tx_cts_n_i && tx_enable_i) begin
                    state_d   = S_START;
                    bit_cnt_d = BIT_LAST;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d    = par_en_q ? S_PARITY : S_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == STOP_LAST)
                        state_d = S_IDLE;
                    else
                        stop_idx_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs follow the state being entered, so each changes on the same edge as that state.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
        rts_n_d = (state_d == S_IDLE);
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // State, counters and registered outputs; synchronous reset aborts any frame
    always_ff @(posedge tck) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            wait_cnt_q <= '0;
            tx_q       <= 1'b1;
            rts_n_q    <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            wait_cnt_q <= wait_cnt_d;
            tx_q       <= tx_d;
            rts_n_q    <= rts_n_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign tx_o       = tx_q;
    assign tx_rts_n_o = rts_n_q;
    assign ready_o    = ready_q;
    assign busy_o     = busy_q;
    assign timeout_o  = timeout_q;

endmodule

// File: doc/uart_tx_req.md
# uart_tx_req

Requesting transmitter for the UART block: accepts bytes on a valid/ready port, raises a transmit request towards the flow controller (`tx_rts_n`), waits for the grant (`tx_cts_n`), then serialises one 8N1/8E1/8O1 frame onto the TX line. It sits between the user-side TX port and the UART flow controller. It is the initiating end of the controller's local-TX handshake.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: `tck` cycles per UART bit, minimum 2.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `CTS_TIMEOUT`, default 1024: maximum cycles spent waiting for a grant, minimum 1.

Ports:
- `tck` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `data_i` in 8: byte to send.
- `valid_i` in 1: `data_i` is valid.
- `ready_o` out 1: block can accept a byte.
- `parity_en_i` in 1: append a parity bit.
- `parity_odd_i` in 1: 1 selects odd parity, 0 selects even.
- `tx_rts_n_o` out 1: request to the flow controller, active-low.
- `tx_cts_n_i` in 1: grant from the flow controller, active-low.
- `tx_enable_i` in 1: transmit path enabled (duplex/master gating).
- `tx_o` out 1: serial line, idles high.
- `busy_o` out 1: a frame is pending or in progress.
- `timeout_o` out 1: one-cycle pulse when a request is abandoned.

## Operation
States are IDLE, REQ, START, DATA, PARITY, STOP.
- **IDLE**
  - `ready_o=1`.
  - On `valid_i&ready_o`, latch `data_i` into the shift register, latch `parity_en_i`/`parity_odd_i`, clear the wait counter, go to REQ.
- **REQ**
  - `tx_rts_n_o=0`.
  - If `tx_cts_n_i==0 && tx_enable_i==1`, go to START and load the bit counter with `CLKS_PER_BIT-1`.
  - Otherwise increment the wait counter.
  - When the wait counter reaches `CTS_TIMEOUT-1` without a grant: pulse `timeout_o`, discard the byte, go to IDLE.
- **START**: `tx_o=0` for one bit time, then go to DATA with bit index 0.
- **DATA**
  - `tx_o` is the shift register LSB; shift right at the end of each bit.
  - Bits go out LSB first, 8 bits.
  - After bit 7, go to PARITY if parity is enabled, else STOP.
- **PARITY**
  - `tx_o` = XOR of the 8 latched bits, XOR `parity_odd`.
  - Held for one bit time, then go to STOP.
- **STOP**
  - `tx_o=1` for `STOP_BITS` bit times, then go to IDLE.
- **Request line**: `tx_rts_n_o=0` in REQ, START, DATA, PARITY and STOP; 1 in IDLE.
- **Grant loss mid-frame**: once START is entered, the frame always completes. `tx_cts_n_i` and `tx_enable_i` are ignored until IDLE.
- **Config stability**: `parity_en_i`/`parity_odd_i` changing mid-frame has no effect.
- `busy_o=1` in every state except IDLE.
- **Bit counter**: counts `CLKS_PER_BIT-1` down to 0. Width is `$clog2(CLKS_PER_BIT)`. Reload on every bit boundary.
- **Wait counter**: width `$clog2(CTS_TIMEOUT+1)`, saturating.

## Timing
- **Reset** (`rst=1` at a `tck` edge):
  - State goes to IDLE.
  - Outputs: `tx_o=1`, `tx_rts_n_o=1`, `ready_o=1`, `busy_o=0`, `timeout_o=0`.
  - All counters are cleared.
  - Reset mid-frame aborts immediately; the line returns high the next cycle.
- **Accept to request**: handshake at edge N gives `tx_rts_n_o=0` from cycle N+1.
- **Grant to start bit**: grant sampled at edge M gives `tx_o=0` from cycle M+1.
  - Minimum accept-to-start-bit latency is 2 cycles (grant already low).
- **Frame length**: `(1+8+parity_en+STOP_BITS)*CLKS_PER_BIT` cycles.
  - `tx_rts_n_o` rises and `ready_o` rises in the cycle after the last stop-bit cycle.
- **Back-to-back**: next byte accepted in the first IDLE cycle. The request line is high for at least 1 cycle between frames, so the flow controller can return to its idle state.
- **Timeout**:
  - `timeout_o` is high exactly one cycle, coincident with the REQ→IDLE transition.
  - `ready_o=1` the following cycle.
- **Simultaneous events in REQ**: grant and timeout in the same cycle → the grant wins and the frame starts.

## Test plan
- **Basic frame**: `CLKS_PER_BIT=4`, no parity, send `0xA5` with grant held low. Required:
  - `tx_rts_n_o` low 1 cycle after accept.
  - `tx_o` sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - Request released after 40 cycles.
- **Parity**: send `0x07`.
  - Even parity: parity bit 1.
  - Odd parity: parity bit 0.
  - Frame is 11 bit times.
- **Delayed grant**:
  - Hold `tx_cts_n_i=1` for 20 cycles, then drop it. Start bit must begin exactly 1 cycle after the grant is sampled, and `tx_o` must stay 1 while waiting.
  - Repeat with `tx_enable_i=0` until cycle 30; start must wait for the enable.
- **Timeout**: `CTS_TIMEOUT=8`, grant never given.
  - `timeout_o` pulses once, 8 cycles after REQ entry.
  - `tx_o` stays 1 throughout.
  - The byte is not sent.
- **Mid-frame events**:
  - Deassert `tx_cts_n_i` during data bit 3; the frame still completes correctly.
  - Assert `rst` during data bit 5: next cycle `tx_o=1`, `tx_rts_n_o=1`, `ready_o=1`.
- **Back-to-back**: `STOP_BITS=2`, send `0x00` then `0xFF` with `valid_i` held. Required:
  - 1-cycle `tx_rts_n_o` high gap between frames.
  - Both frames bit-exact.
